// File: rtl/dp_ram.sv
// ---------------------------------------------------------------------------
// dp_ram: single-clock true dual-port RAM with per-byte write enables,
// selectable same-port read-during-write behaviour, an optional output
// register stage and a clear engine that zeroes the array after reset or
// on request.
//
// Ports
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   clear_req            pulse: start a full-array clear (only when ready)
//   busy                 high during reset and while a clear is running
//   collision            registered pulse: both ports wrote the same address
//   en_x, we_x, be_x     port enable, write enable, byte write enables
//   addr_x, din_x        word address and write data
//   dout_x, valid_x      read data and its qualifier (latency 1 or 2)
// ---------------------------------------------------------------------------
module dp_ram #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  busy,
    output logic                  collision,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [DATA_W/8-1:0]   be_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     din_a,
    output logic [DATA_W-1:0]     dout_a,
    output logic                  valid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [DATA_W/8-1:0]   be_b,
    input  logic [ADDR_W-1:0]     addr_b,
    input  logic [DATA_W-1:0]     din_b,
    output logic [DATA_W-1:0]     dout_b,
    output logic                  valid_b
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              ready;
    logic              acc_a, acc_b, wr_a, wr_b;

    logic [DATA_W-1:0] mem [DEPTH];

    // First pipeline stage (registered array read)
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              v1_a, v1_b;

    assign ready = (state == ST_READY);
    assign busy  = (state == ST_CLEAR);
    // Port traffic is only accepted when no clear is running
    assign acc_a = en_a & ready;
    assign acc_b = en_b & ready;
    assign wr_a  = acc_a & we_a;
    assign wr_b  = acc_b & we_b;

    // Clear engine: walks every address once, then hands over to the ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        state   <= ST_READY;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    if (clear_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // Array write. Port B is applied before port A so that, on a same-address
    // collision, A's enabled bytes override B's while B still fills the
    // bytes A leaves untouched.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && be_b[i])
                    mem[addr_b][i*8 +: 8] <= din_b[i*8 +: 8];
            end
            for (int i = 0; i < NB; i++) begin
                if (wr_a && be_a[i])
                    mem[addr_a][i*8 +: 8] <= din_a[i*8 +: 8];
            end
        end
    end

    // Registered read. The array read returns the pre-write word; in
    // write-first mode a port's own written bytes are bypassed from din.
    // The other port's write is never bypassed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_a      <= '0;
            rd_b      <= '0;
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            collision <= 1'b0;
        end else begin
            v1_a      <= acc_a;
            v1_b      <= acc_b;
            collision <= wr_a & wr_b & (addr_a == addr_b);
            if (acc_a) begin
                for (int i = 0; i < NB; i++)
                    rd_a[i*8 +: 8] <= (RDW_MODE != 0 && wr_a && be_a[i]) ?
                                      din_a[i*8 +: 8] : mem[addr_a][i*8 +: 8];
            end
            if (acc_b) begin
                for (int i = 0; i < NB; i++)
                    rd_b[i*8 +: 8] <= (RDW_MODE != 0 && wr_b && be_b[i]) ?
                                      din_b[i*8 +: 8] : mem[addr_b][i*8 +: 8];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q_a, q_b;
            logic              v2_a, v2_b;

            // Runs regardless of the clear state so in-flight reads finish
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_a  <= '0;
                    q_b  <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) q_a <= rd_a;
                    if (v1_b) q_b <= rd_b;
                end
            end

            assign dout_a  = q_a;
            assign dout_b  = q_b;
            assign valid_a = v2_a;
            assign valid_b = v2_b;
        end else begin : g_no_out_reg
            assign dout_a  = rd_a;
            assign dout_b  = rd_b;
            assign valid_a = v1_a;
            assign valid_b = v1_b;
        end
    endgenerate

endmodule
